aes_encrypt_multikey: RTL
=========================

# aes_encrypt_multikey

Parametrised AES encryption core supporting 128/192/256-bit keys, built on the same T-box round datapath as our AES-128 encryptor. A key is loaded once, expanded into an on-chip round-key store, and then reused for any number of blocks. Each block takes one round per cycle. The block sits between the host key/data registers and the cipher output bus.

## Interface
- MAX_KEY_BITS, 256, largest supported key: 128, 192 or 256. Sets round-key store depth to 4*(Nr_max+1) words: 44, 52 or 60.
- clk  in  1  rising-edge clock
- nrst  in  1  reset, asynchronous, active-low (one clock; reset async active-low)
- key_load  in  1  request key expansion. Accepted only when busy=0.
- key_len  in  2  0=128, 1=192, 2=256, 3=reserved. Sampled with key_load.
- key  in  256  key words MSB-first. 128 uses key[255:128]; 192 uses key[255:64].
- key_ready  out  1  round-key store is valid for the last accepted key
- key_err  out  1  one-cycle pulse: key_len reserved or above MAX_KEY_BITS
- start  in  1  encrypt request. Accepted only when busy=0 and key_ready=1.
- plain_text  in  128  sampled on the accepting edge of start
- cipher_text  out  128  result register. Holds until the next finish.
- finish  out  1  one-cycle pulse when cipher_text updates
- busy  out  1  high in EXPAND and ENCRYPT

## Operation
- FSM states: IDLE, EXPAND, ENCRYPT.
- IDLE + key_load, legal key_len:
  - latch key and Nk (4/6/8); Nr = Nk+6
  - clear key_ready; go to EXPAND
- IDLE + key_load, illegal key_len:
  - pulse key_err; stay in IDLE; key_ready and store unchanged
- key_load and start in the same IDLE cycle: key_load wins; start is dropped.
- key_load or start while busy=1: ignored, no error.
- EXPAND:
  - write w[0..Nk-1] from key on entry
  - then generate one word per cycle for i = Nk .. 4(Nr+1)-1:
    - w[i] = w[i-Nk] ^ t, where t = w[i-1]
    - if i mod Nk = 0: t = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk]
    - if Nk=8 and i mod 8 = 4: t = SubWord(w[i-1])
  - after the last word: set key_ready, go to IDLE
- IDLE + start with key_ready=1:
  - latch plain_text; go to ENCRYPT
  - state = plain_text ^ w[0..3]
  - rounds 1..Nr-1: T-box SubBytes/ShiftRows/MixColumns ^ w[4r..4r+3]
  - round Nr: S-box bytes extracted from T-box outputs, no MixColumns
  - on completion: load cipher_text, pulse finish, go to IDLE
- All arithmetic is GF(2^8)/XOR only. Round counter is 4 bits. Word index is 6 bits.

## Timing
- Reset values:
  - FSM = IDLE
  - key_ready = 0, key_err = 0, finish = 0, busy = 0
  - cipher_text = 0, round-key store = 0
- Expansion: key_ready rises exactly 4(Nr+1)-Nk+1 cycles after the accepting edge, i.e. 41 / 47 / 53 for 128/192/256.
- Encryption: T-box lookups are registered (1 cycle) and give one round per cycle. finish pulses Nr+2 cycles after the accepting edge: 12 / 14 / 16. cipher_text is valid in the same cycle.
- busy drops in the cycle finish or key_ready rises, so a back-to-back start is accepted on the next edge.
- Reset mid-operation aborts the current operation: no finish; key_ready=0; a new key_load is required.
- cipher_text is never partially updated.

## Structure
- Package aes_pkg holds:
  - key_len encodings
  - Nk/Nr lookup functions
  - Rcon table
  - FSM state enum
- Reused Te0box..Te3box and Sbox leaf modules.
- One sub-module, aes_key_expand, owns:
  - the word index counter
  - the Nk-dependent tap logic
  - the 4 SubWord S-boxes
  - the round-key store, with a combinational 4-word read port addressed by round
- The top holds the FSM, the round counter, the T-box array and the output register.

## Test plan
- FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a. key_ready after 41 cycles; finish 12 cycles after start.
- FIPS-197 C.2 (key 000102..17) -> dda97ca4864cdfe06eaf70a0ec0d7191, finish at 14. C.3 (key 000102..1f) -> 8ea2b7ca516745bfeafc49904b496089, finish at 16.
- Appendix A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> store w[43] = b6630ca6. Then 100 back-to-back starts with random pt match the reference model, one finish per start, no idle gaps beyond 1 cycle.
- start during EXPAND, key_load during ENCRYPT, and key_load+start together in IDLE -> all ignored or resolved as specified; results unchanged.
- key_len=3, and key_len=2 with MAX_KEY_BITS=128 -> key_err pulse, key_ready keeps prior value.
- nrst pulsed mid-EXPAND and mid-ENCRYPT -> all outputs return to reset values; start is ignored until a new key expands.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared encodings, key-size lookups, GF(2^8) helpers and FSM states for the AES core.
package aes_pkg;

    typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2, KL_RSVD = 2'd3} key_len_t;

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, ENCRYPT = 2'd2} fsm_t;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        return len == KL_192 ? 4'd6 : len == KL_256 ? 4'd8 : 4'd4;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        return nk_of(len) + 4'd6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] t;
        t = a;
        for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), a);
        t = gf_mul(t, t);
        return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
    endfunction

    // Rcon[i] for i = 1..10, as the high byte of the round constant word.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < 10; k++) r = k < int'(i) ? xtime(r) : r;
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expand.sv
// aes_key_expand: one-word-per-cycle key schedule into a round-key store read four words per round.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    input  logic         expand,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         last
);
    localparam int DEPTH = 4 * (MAX_KEY_BITS / 32 + 7);

    logic [31:0]  w [DEPTH];
    logic [255:0] key_q;
    logic [3:0]   nk, phase, rc;
    logic [5:0]   idx, last_idx, base;
    logic         first;
    logic [31:0]  prev, back, sub_in, sub_out, t;

    // phase tracks i mod Nk and rc tracks i/Nk so no divider is needed
    assign prev     = w[idx - 6'd1];
    assign back     = w[idx - {2'b00, nk}];
    assign sub_in   = phase == 4'd0 ? {prev[23:0], prev[31:24]} : prev;
    assign t        = phase == 4'd0 ? sub_out ^ {rcon(rc), 24'h0} : (nk == 4'd8 && phase == 4'd4) ? sub_out : prev;
    assign last_idx = {nk, 2'b00} + 6'd27;
    assign last     = expand && !first && idx == last_idx;
    assign base     = {rd_round, 2'b00};

    for (genvar j = 0; j < 4; j++) begin : g_sub
        Sbox u_sb (.x(sub_in[8*j +: 8]), .y(sub_out[8*j +: 8]));
    end

    always_comb begin
        rd_key = '0;
        for (int j = 0; j < 4; j++)
            rd_key[127 - 32*j -: 32] = (int'(base) + j < DEPTH) ? w[base + 6'(j)] : '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int j = 0; j < DEPTH; j++) w[j] <= '0;
            key_q <= '0;
            nk    <= 4'd4;
            phase <= '0;
            rc    <= '0;
            idx   <= '0;
            first <= 1'b0;
        end else if (load) begin
            key_q <= key;
            nk    <= nk_of(key_len);
            first <= 1'b1;
        end else if (expand && first) begin
            for (int j = 0; j < 8; j++) if (j < int'(nk)) w[j] <= key_q[255 - 32*j -: 32];
            idx   <= {2'b00, nk};
            phase <= '0;
            rc    <= 4'd1;
            first <= 1'b0;
        end else if (expand) begin
            w[idx] <= back ^ t;
            idx    <= idx + 6'd1;
            phase  <= phase == nk - 4'd1 ? 4'd0 : phase + 4'd1;
            rc     <= phase == nk - 4'd1 ? rc + 4'd1 : rc;
        end
    end

endmodule

// File: rtl/aes_tbox.sv
// Sbox / Te0box..Te3box: byte substitution leaf and the four MixColumns-rotated T-box lookups.
module Sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    assign y = sbox_f(x);
endmodule

module Te0box
    import aes_pkg::*;
(
    input  logic [7:0]  x,
    output logic [31:0] y
);
    logic [7:0] s, s2;
    Sbox u_s (.x(x), .y(s));
    assign s2 = xtime(s);
    assign y  = {s2, s, s, s2 ^ s};
endmodule

module Te1box
    import aes_pkg::*;
(
    input  logic [7:0]  x,
    output logic [31:0] y
);
    logic [7:0] s, s2;
    Sbox u_s (.x(x), .y(s));
    assign s2 = xtime(s);
    assign y  = {s2 ^ s, s2, s, s};
endmodule

module Te2box
    import aes_pkg::*;
(
    input  logic [7:0]  x,
    output logic [31:0] y
);
    logic [7:0] s, s2;
    Sbox u_s (.x(x), .y(s));
    assign s2 = xtime(s);
    assign y  = {s, s2 ^ s, s2, s};
endmodule

module Te3box
    import aes_pkg::*;
(
    input  logic [7:0]  x,
    output logic [31:0] y
);
    logic [7:0] s, s2;
    Sbox u_s (.x(x), .y(s));
    assign s2 = xtime(s);
    assign y  = {s, s, s2 ^ s, s2};
endmodule

// File: rtl/aes_encrypt_multikey.sv
// aes_encrypt_multikey: AES-128/192/256 encryptor, one T-box round per cycle over a stored key schedule.
module aes_encrypt_multikey
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         key_load,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         key_ready,
    output logic         key_err,
    input  logic         start,
    input  logic [127:0] plain_text,
    output logic [127:0] cipher_text,
    output logic         finish,
    output logic         busy
);
    fsm_t         st;
    logic [3:0]   rnd, nr;
    logic [127:0] blk, rk, mid, fin;
    logic         len_ok, kx_last;

    assign len_ok = key_len != KL_RSVD && 32 * int'(nk_of(key_len)) <= MAX_KEY_BITS;

    aes_key_expand #(.MAX_KEY_BITS(MAX_KEY_BITS)) u_kx (
        .clk      (clk),
        .nrst     (nrst),
        .load     (st == IDLE && key_load && len_ok),
        .key_len  (key_len),
        .key      (key),
        .expand   (st == EXPAND),
        .rd_round (rnd),
        .rd_key   (rk),
        .last     (kx_last)
    );

    // Column c takes row r from column (c+r)%4 (ShiftRows); the final round pulls the bare S-box byte out of each T-box word
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] t0, t1, t2, t3;
        Te0box u_t0 (.x(blk[127 - 32*c -: 8]),         .y(t0));
        Te1box u_t1 (.x(blk[119 - 32*((c+1)%4) -: 8]), .y(t1));
        Te2box u_t2 (.x(blk[111 - 32*((c+2)%4) -: 8]), .y(t2));
        Te3box u_t3 (.x(blk[103 - 32*((c+3)%4) -: 8]), .y(t3));
        assign mid[127 - 32*c -: 32] = t0 ^ t1 ^ t2 ^ t3;
        assign fin[127 - 32*c -: 32] = {t0[23:16], t1[7:0], t2[31:24], t3[31:24]};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st          <= IDLE;
            rnd         <= '0;
            nr          <= '0;
            blk         <= '0;
            cipher_text <= '0;
            finish      <= 1'b0;
            busy        <= 1'b0;
            key_ready   <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            finish  <= 1'b0;
            key_err <= 1'b0;
            case (st)
                IDLE:
                    if (key_load) begin
                        if (len_ok) begin
                            nr        <= nr_of(key_len);
                            key_ready <= 1'b0;
                            busy      <= 1'b1;
                            st        <= EXPAND;
                        end else
                            key_err <= 1'b1;
                    end else if (start && key_ready) begin
                        blk  <= plain_text;
                        rnd  <= '0;
                        busy <= 1'b1;
                        st   <= ENCRYPT;
                    end
                EXPAND:
                    if (kx_last) begin
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                        st        <= IDLE;
                    end
                ENCRYPT: begin
                    rnd <= rnd + 4'd1;
                    blk <= (rnd == 4'd0 ? blk : rnd == nr ? fin : mid) ^ rk;
                    if (rnd == nr + 4'd1) begin
                        cipher_text <= blk;
                        finish      <= 1'b1;
                        busy        <= 1'b0;
                        st          <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
